ex_div_unit: RTL and testbench

//  Iterative radix-2 restoring divider for the EX stage, serving DIV and DIVU.
//  EX starts it with two 32-bit operands and holds the pipeline through stallreq_for_div.
//  It returns {remainder, quotient}, which EX packs into hilo_bus (hi = remainder, lo = quotient).

---
 rtl/ex_div_unit.sv | 91 +++++++++
 tb/tb_ex_div_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider for DIV/DIVU in the EX stage
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   flush                abandons any division in progress
//   div_start            EX requests a division (operands sampled only in IDLE)
//   div_signed           1 = DIV (two's complement), 0 = DIVU
//   div_opdata1/2        dividend / divisor
//   div_ack              EX consumes the result (only honoured while ready)
//   div_result           {remainder, quotient}, held until overwritten
//   div_ready            result valid (DONE state)
//   stallreq_for_div     combinational stall request to freeze IF/ID/EX
module ex_div_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                div_start,
   input  logic                div_signed,
   input  logic [DATA_W-1:0]   div_opdata1,
   input  logic [DATA_W-1:0]   div_opdata2,
   input  logic                div_ack,
   output logic [2*DATA_W-1:0] div_result,
   output logic                div_ready,
   output logic                stallreq_for_div
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nx;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] dvd, dvs, rem, rem_nx, q_nx, mag_a, mag_b, q_fix, r_fix;
   logic [DATA_W:0]   trial;
   logic              neg_q, neg_r, last;
   assign mag_a = (div_signed && div_opdata1[DATA_W-1]) ? -div_opdata1 : div_opdata1;
   assign mag_b = (div_signed && div_opdata2[DATA_W-1]) ? -div_opdata2 : div_opdata2;
   // dvd doubles as the quotient register: dividend bits shift out the top while
   // quotient bits shift in at the bottom
   assign trial  = {rem, dvd[DATA_W-1]} - {1'b0, dvs};
   assign rem_nx = trial[DATA_W] ? {rem[DATA_W-2:0], dvd[DATA_W-1]} : trial[DATA_W-1:0];
   assign q_nx   = {dvd[DATA_W-2:0], ~trial[DATA_W]};
   assign q_fix  = neg_q ? -q_nx : q_nx;
   assign r_fix  = neg_r ? -rem_nx : rem_nx;
   assign last   = count == CNT_W'(DATA_W - 1);
   assign div_ready = state == DONE;
   assign stallreq_for_div = (state == IDLE && div_start && !flush) || state == CALC;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      if (flush) state_nx = IDLE;
      else
         case (state)
            IDLE:    if (div_start) state_nx = (div_opdata2 == '0) ? DONE : CALC;
            CALC:    if (last) state_nx = DONE;
            DONE:    if (div_ack) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         dvd        <= '0;
         dvs        <= '0;
         rem        <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         div_result <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (state == IDLE && div_start) begin
         if (div_opdata2 == '0) begin
            // divide-by-zero: architecturally defined result, no sign fixup
            div_result <= {div_opdata1, {DATA_W{1'b1}}};
         end else begin
            dvd   <= mag_a;
            dvs   <= mag_b;
            rem   <= '0;
            count <= '0;
            neg_q <= div_signed & (div_opdata1[DATA_W-1] ^ div_opdata2[DATA_W-1]);
            neg_r <= div_signed & div_opdata1[DATA_W-1];
         end
      end else if (state == CALC) begin
         rem   <= rem_nx;
         dvd   <= q_nx;
         count <= count + 1'b1;
         if (last) div_result <= {r_fix, q_fix};
      end
   end
endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: table-driven, hand-written and random checks of ex_div_unit
module tb_ex_div_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        div_start = 1'b0;
   logic        div_signed = 1'b0;
   logic [31:0] div_opdata1 = '0;
   logic [31:0] div_opdata2 = '0;
   logic        div_ack = 1'b0;
   logic [63:0] div_result;
   logic        div_ready;
   logic        stallreq_for_div;
   int          n_vec = 0;
   int          n_err = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [63:0] exp;
   } vec_t;
   vec_t tbl[8];

   ex_div_unit dut (
      .clk(clk), .rst(rst), .flush(flush), .div_start(div_start),
      .div_signed(div_signed), .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
      .div_ack(div_ack), .div_result(div_result), .div_ready(div_ready),
      .stallreq_for_div(stallreq_for_div)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic; signed division truncates toward zero
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa, sb, q, r;
      if (b == 0) return {a, 32'hFFFF_FFFF};
      if (!s) return {a % b, a / b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Called at a negedge; returns at the negedge after the ack cycle (ack still 1)
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
      logic [63:0] exp, held;
      int t, lat, bad, bad_hold;
      div_ack = 1'b0;
      div_start = 1'b1;
      div_opdata1 = a;
      div_opdata2 = b;
      div_signed = s;
      #1;
      chk("idle_ready", {63'd0, div_ready}, 64'd0);
      chk("start_stall", {63'd0, stallreq_for_div}, 64'd1);
      exp = model(a, b, s);
      lat = (b == 0) ? 1 : 33;
      t = 0;
      bad = 0;
      while (!div_ready && t < 40) begin
         @(negedge clk);
         t++;
         div_start = 1'b0;
         if (!div_ready) begin
            if (!stallreq_for_div) bad++;
            div_ack = 1'($urandom);
            div_opdata1 = $urandom;
            div_opdata2 = $urandom;
            div_signed = 1'($urandom);
         end
      end
      div_ack = 1'b0;
      chk("latency", 64'(t), 64'(lat));
      chk("calc_stall", 64'(bad), 64'd0);
      chk("result", div_result, exp);
      chk("ready_stall", {63'd0, stallreq_for_div}, 64'd0);
      held = div_result;
      bad_hold = 0;
      repeat (hold) begin
         @(negedge clk);
         if (!div_ready || div_result !== held) bad_hold++;
         div_opdata1 = $urandom;
         div_opdata2 = $urandom;
      end
      if (hold > 0) chk("hold_stable", 64'(bad_hold), 64'd0);
      div_ack = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      div_ack = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int cnt;
      logic [31:0] ra, rb;
      tbl[0] = '{32'd100, 32'd7, 1'b0, {32'd2, 32'd14}};
      tbl[1] = '{32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
      tbl[2] = '{32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}};
      tbl[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}};
      tbl[4] = '{32'h0000_1234, 32'd0, 1'b0, {32'h0000_1234, 32'hFFFF_FFFF}};
      tbl[5] = '{32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0, 32'hFFFF_FFFF}};
      tbl[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0}};
      tbl[7] = '{32'hFFFF_FFF9, 32'd0, 1'b1, {32'hFFFF_FFF9, 32'hFFFF_FFFF}};
      repeat (2) @(negedge clk);
      chk("rst_ready", {63'd0, div_ready}, 64'd0);
      chk("rst_result", div_result, 64'd0);
      chk("rst_stall", {63'd0, stallreq_for_div}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         chk("tbl_model", model(tbl[i].a, tbl[i].b, tbl[i].s), tbl[i].exp);
         run_div(tbl[i].a, tbl[i].b, tbl[i].s, (i == 0) ? 3 : 0);
         idle(1);
      end
      // back-to-back: second start in the cycle right after the ack
      run_div(32'd1000, 32'd33, 1'b0, 0);
      run_div(32'hFFFF_FC18, 32'd33, 1'b1, 1);
      idle(2);
      // flush at t10 of CALC
      div_start = 1'b1;
      div_opdata1 = 32'd5000;
      div_opdata2 = 32'd3;
      div_signed = 1'b0;
      @(negedge clk);
      div_start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_ready", {63'd0, div_ready}, 64'd0);
      chk("flush_idle_stall", {63'd0, stallreq_for_div}, 64'd0);
      // flush together with start must not launch a division
      div_start = 1'b1;
      flush = 1'b1;
      #1;
      chk("flush_start_stall", {63'd0, stallreq_for_div}, 64'd0);
      @(negedge clk);
      div_start = 1'b0;
      flush = 1'b0;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (div_ready || stallreq_for_div) cnt++;
      end
      chk("flush_no_ready", 64'(cnt), 64'd0);
      // asynchronous reset mid-CALC
      run_div(32'd77, 32'd5, 1'b0, 0);
      idle(1);
      div_start = 1'b1;
      div_opdata1 = 32'd999;
      div_opdata2 = 32'd4;
      @(negedge clk);
      div_start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_result", div_result, 64'd0);
      chk("arst_ready", {63'd0, div_ready}, 64'd0);
      chk("arst_stall", {63'd0, stallreq_for_div}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_div(32'd999, 32'd4, 1'b0, 0);
      idle(1);
      // random operands against the reference model
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = $urandom_range(1, 15);
            2: rb = -32'($urandom_range(1, 15));
            3: ra = 32'h8000_0000;
            default: ;
         endcase
         run_div(ra, rb, 1'($urandom), $urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
